// File: rtl/instr_mem_loader.sv
// Packs UART bytes MSB-first into words, writes them at 0,4,8,... and then hands the memory port to the CPU.
// Write strobe one cycle after the 4th byte; ownership switches after the all-ones halt word is written.
module instr_mem_loader #(
  parameter int                NBITS     = 32,
  parameter int                CELDAS    = 160,
  parameter logic [NBITS-1:0]  HALT_WORD = '1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [7:0]       i_rx_data,
  input  logic             i_rx_valid,
  input  logic [NBITS-1:0] i_cpu_pc,
  output logic [NBITS-1:0] o_mem_addr,
  output logic [NBITS-1:0] o_mem_wdata,
  output logic             o_mem_we,
  output logic             o_cpu_stall,
  output logic             o_load_done,
  output logic             o_error,
  output logic [NBITS-1:0] o_word_count
);

  typedef enum logic [2:0] {IDLE, RECV, WRITE, RUN, ERROR} state_t;

  localparam logic [NBITS-1:0] LAST_ADDR = NBITS'(CELDAS - 4);
  localparam logic [NBITS-1:0] STEP      = NBITS'(4);

  state_t           state_q, state_d;
  logic [NBITS-1:0] addr_q, addr_d;
  logic [1:0]       idx_q, idx_d;
  logic [NBITS-1:0] asm_q, asm_d;
  logic [NBITS-1:0] cnt_q, cnt_d;
  logic [NBITS-1:0] wdata_q, wdata_d;
  logic             we_q, we_d;
  logic             stall_q, stall_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [NBITS-1:0] shifted;

  assign shifted = {asm_q[NBITS-9:0], i_rx_data};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    asm_d   = asm_q;
    cnt_d   = cnt_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    stall_d = stall_q;
    done_d  = done_q;
    err_d   = err_q;

    case (state_q)
      RECV: begin
        if (i_rx_valid) begin
          asm_d = shifted;
          if (idx_q == 2'd3) begin
            idx_d = 2'd0;
            if (addr_q > LAST_ADDR) begin
              state_d = ERROR;
              err_d   = 1'b1;
            end else begin
              state_d = WRITE;
              we_d    = 1'b1;
              wdata_d = shifted;
            end
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      WRITE: begin
        addr_d = addr_q + STEP;
        cnt_d  = cnt_q + NBITS'(1);
        if (wdata_q == HALT_WORD) begin
          state_d = RUN;
          stall_d = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = RECV;
        end
        // a byte landing during the write cycle starts the next word
        if (i_rx_valid) begin
          asm_d = shifted;
          idx_d = 2'd1;
        end
      end
      IDLE, RUN, ERROR: ;
      default: state_d = IDLE;
    endcase

    // start overrides everything, including a coincident byte; an in-flight strobe still completes
    if (i_start) begin
      state_d = RECV;
      addr_d  = '0;
      idx_d   = 2'd0;
      cnt_d   = '0;
      wdata_d = wdata_q;
      we_d    = 1'b0;
      stall_d = 1'b1;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      idx_q   <= 2'd0;
      asm_q   <= '0;
      cnt_q   <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      stall_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      cnt_q   <= cnt_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      stall_q <= stall_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign o_mem_addr   = (state_q == RUN) ? i_cpu_pc : addr_q;
  assign o_mem_wdata  = wdata_q;
  assign o_mem_we     = we_q;
  assign o_cpu_stall  = stall_q;
  assign o_load_done  = done_q;
  assign o_error      = err_q;
  assign o_word_count = cnt_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: directed scenarios, then random traffic checked every cycle against a queue-based model.
module tb_instr_mem_loader;
  localparam int          CELDAS = 16;
  localparam logic [31:0] HALT   = 32'hFFFFFFFF;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_start = 1'b0;
  logic [7:0]  i_rx_data = 8'h00;
  logic        i_rx_valid = 1'b0;
  logic [31:0] i_cpu_pc = 32'h0;
  logic [31:0] o_mem_addr, o_mem_wdata, o_word_count;
  logic        o_mem_we, o_cpu_stall, o_load_done, o_error;

  int errors = 0;
  int checks = 0;

  instr_mem_loader #(.NBITS(32), .CELDAS(CELDAS), .HALT_WORD(HALT)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_rx_data(i_rx_data),
    .i_rx_valid(i_rx_valid), .i_cpu_pc(i_cpu_pc), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_we(o_mem_we), .o_cpu_stall(o_cpu_stall),
    .o_load_done(o_load_done), .o_error(o_error), .o_word_count(o_word_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0=idle 1=loading 2=cpu owns memory 3=overflowed
  int          m_phase = 0;
  logic [7:0]  mq[$];
  logic [31:0] m_addr = 0, m_cnt = 0, m_last = 0;
  bit          m_wr = 0;

  always @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      m_phase = 0; mq.delete(); m_addr = 0; m_cnt = 0; m_last = 0; m_wr = 0;
    end else begin
      if (m_wr) begin
        m_wr = 0;
        m_addr = m_addr + 4;
        m_cnt = m_cnt + 1;
        if (m_last == HALT) m_phase = 2;
      end
      if (i_start) begin
        m_phase = 1; mq.delete(); m_addr = 0; m_cnt = 0;
      end else if (m_phase == 1 && i_rx_valid) begin
        mq.push_back(i_rx_data);
        if (mq.size() == 4) begin
          logic [31:0] w;
          w = {mq[0], mq[1], mq[2], mq[3]};
          mq.delete();
          if (m_addr > 32'(CELDAS - 4)) m_phase = 3;
          else begin
            m_wr = 1;
            m_last = w;
          end
        end
      end
    end
  end

  logic [31:0] wa[$], wd[$];

  always @(negedge i_clk) begin
    chk("we", 32'(o_mem_we), 32'(m_wr));
    chk("wdata", o_mem_wdata, m_last);
    chk("stall", 32'(o_cpu_stall), 32'(m_phase != 2));
    chk("load_done", 32'(o_load_done), 32'(m_phase == 2));
    chk("error", 32'(o_error), 32'(m_phase == 3));
    chk("word_count", o_word_count, m_cnt);
    chk("mem_addr", o_mem_addr, (m_phase == 2) ? i_cpu_pc : m_addr);
    if (o_mem_we) begin
      wa.push_back(o_mem_addr);
      wd.push_back(o_mem_wdata);
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_valid = 1'b1;
    i_rx_data  = b;
    tick();
    i_rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]); send_byte(w[23:16]); send_byte(w[15:8]); send_byte(w[7:0]);
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  initial begin
    int base;
    tick(); tick();
    chk("rst_stall", 32'(o_cpu_stall), 32'd1);
    chk("rst_we", 32'(o_mem_we), 32'd0);
    chk("rst_count", o_word_count, 32'd0);
    chk("rst_error", 32'(o_error), 32'd0);
    chk("rst_done", 32'(o_load_done), 32'd0);
    chk("rst_addr", o_mem_addr, 32'd0);
    i_reset = 1'b1;
    tick();

    // bytes before start are ignored
    send_byte(8'h55);
    pulse_start();
    send_word(32'h00230820);
    chk("w0_we", 32'(o_mem_we), 32'd1);
    chk("w0_addr", o_mem_addr, 32'd0);
    chk("w0_data", o_mem_wdata, 32'h00230820);
    chk("model_w0", m_last, 32'h00230820);
    tick();
    chk("w0_count", o_word_count, 32'd1);
    chk("model_cnt", m_cnt, 32'd1);
    chk("w0_stall", 32'(o_cpu_stall), 32'd1);

    // back-to-back words: first byte of each lands in the write cycle
    send_word(32'h11223344);
    send_word(32'hA5A55A5A);
    send_word(HALT);
    tick();
    i_cpu_pc = 32'h14;
    #1;
    chk("run_done", 32'(o_load_done), 32'd1);
    chk("run_stall", 32'(o_cpu_stall), 32'd0);
    chk("run_addr", o_mem_addr, 32'h14);
    chk("log_n4", 32'(wa.size()), 32'd4);
    chk("log1_data", wd[1], 32'h11223344);
    chk("log2_addr", wa[2], 32'd8);
    chk("log2_data", wd[2], 32'hA5A55A5A);
    chk("log3_addr", wa[3], 32'd12);
    chk("log3_data", wd[3], HALT);

    send_byte(8'hAA); send_byte(8'hAB); send_byte(8'hAC); send_byte(8'hAD);
    pulse_start();
    chk("restart_stall", 32'(o_cpu_stall), 32'd1);
    chk("restart_done", 32'(o_load_done), 32'd0);
    chk("run_no_write", 32'(wa.size()), 32'd4);

    // overflow with 4-word memory
    base = wa.size();
    for (int k = 1; k <= 5; k++) send_word(32'h01010101 * k);
    chk("ovf_error", 32'(o_error), 32'd1);
    chk("ovf_we", 32'(o_mem_we), 32'd0);
    chk("ovf_count", o_word_count, 32'd4);
    chk("ovf_stall", 32'(o_cpu_stall), 32'd1);
    chk("ovf_nwrites", 32'(wa.size() - base), 32'd4);
    chk("ovf_last_addr", wa[wa.size()-1], 32'd12);
    pulse_start();
    chk("ovf_clear", 32'(o_error), 32'd0);
    send_word(32'hCAFEF00D);
    chk("post_ovf_addr", o_mem_addr, 32'd0);
    chk("post_ovf_data", o_mem_wdata, 32'hCAFEF00D);
    tick();

    // reset mid-word
    send_byte(8'h12); send_byte(8'h34);
    #1 i_reset = 1'b0;
    #2 i_reset = 1'b1;
    tick();
    pulse_start();
    send_word(32'hDEADBEEF);
    chk("rst_mid_we", 32'(o_mem_we), 32'd1);
    chk("rst_mid_addr", o_mem_addr, 32'd0);
    chk("rst_mid_data", o_mem_wdata, 32'hDEADBEEF);
    tick();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(99);
      i_cpu_pc = $urandom;
      if (r < 3) begin
        i_rx_valid = ($urandom_range(1) == 1);
        i_rx_data = 8'($urandom);
        pulse_start();
        i_rx_valid = 1'b0;
      end else if (r < 4) begin
        #1 i_reset = 1'b0;
        #2 i_reset = 1'b1;
        tick();
      end else if (r < 10) begin
        send_word(HALT);
      end else if (r < 70) begin
        send_byte(8'($urandom));
      end else begin
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Sequences writes into the instruction memory and arbitrates its single address port between this loader and the CPU fetch stage.
- Assembles bytes from the UART receiver into 32-bit instructions and writes them at consecutive word addresses (0, 4, 8, …), which matches the byte-addressed PC indexing.
- Hands memory ownership to the CPU after the halt word (all ones) is written, and holds the CPU stalled until then.

Parameters:
- NBITS, 32, data/address width.
- CELDAS, 160, instruction memory depth in cells. Writable addresses are 0..CELDAS-4 in steps of 4.
- HALT_WORD, 32'hFFFFFFFF, instruction value that terminates a load.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_reset  input  1  asynchronous reset, active-low (0 = reset).
- i_start  input  1  one-cycle pulse; begins a new load at address 0.
- i_rx_data  input  8  received byte.
- i_rx_valid  input  1  i_rx_data is valid this cycle; one byte per asserted cycle.
- i_cpu_pc  input  NBITS  CPU fetch address.
- o_mem_addr  output  NBITS  address presented to the instruction memory.
- o_mem_wdata  output  NBITS  write data to the instruction memory.
- o_mem_we  output  1  write strobe to the instruction memory, one cycle per word.
- o_cpu_stall  output  1  1 = CPU must hold its PC and not fetch.
- o_load_done  output  1  1 while the CPU owns the memory.
- o_error  output  1  1 after an overflow abort.
- o_word_count  output  NBITS  number of words written in the current load.

Behaviour:
- Reset (i_reset=0, takes effect immediately):
  - state=IDLE.
  - o_mem_we=0, o_mem_wdata=0, internal write address=0, byte index=0, o_word_count=0.
  - o_cpu_stall=1, o_load_done=0, o_error=0.
  - Reset during any state aborts the load; memory contents written so far are left as-is.
- States:
  - IDLE:
    - o_cpu_stall=1; rx bytes ignored.
    - i_start → RECV, with address=0, byte index=0, o_word_count=0, o_error=0.
  - RECV:
    - On each i_rx_valid, shift the byte into the assembly register, MSB first: the first byte received becomes bits [31:24].
    - Byte index counts 0..3.
    - On the 4th byte → WRITE.
  - WRITE (exactly 1 cycle):
    - o_mem_we=1, o_mem_wdata=assembled word, o_mem_addr=write address.
    - Next cycle: address+=4, o_word_count+=1.
    - If word==HALT_WORD → RUN; else → RECV.
    - An i_rx_valid arriving in WRITE is accepted as byte 0 of the next word, so no byte is lost.
  - RUN:
    - o_cpu_stall=0, o_load_done=1.
    - o_mem_addr=i_cpu_pc (combinational pass-through); o_mem_we=0; rx bytes ignored.
    - i_start → RECV, restarting at address 0; stall reasserts the next cycle.
  - ERROR:
    - o_error=1, o_cpu_stall=1, o_mem_we=0; rx bytes ignored.
    - Only i_start (→ RECV, clears o_error) or reset exits.
- Latency: 4th byte sampled at edge n → o_mem_we high for the cycle following edge n → address and count update at edge n+1.
- Overflow: on entering WRITE with address > CELDAS-4:
  - no write occurs (o_mem_we stays 0);
  - → ERROR;
  - o_word_count unchanged.
- The halt word is itself written to memory before the transition to RUN.
- o_mem_addr in non-RUN states = registered write address.
- i_start in RECV or WRITE: restarts the load at address 0 and discards the partial word. If it coincides with o_mem_we, that write completes.
- i_start and i_rx_valid in the same cycle: i_start wins; the byte is discarded.
- All outputs are registered except o_mem_addr in RUN.

Test Plan:
- Reset, pulse i_start, send bytes 00 23 08 20 → one o_mem_we cycle with addr=0, wdata=0x00230820; word_count=1; stall=1.
- Send 3 words then FF FF FF FF → writes at 0, 4, 8 and 12 (0xFFFFFFFF); then load_done=1, stall=0; o_mem_addr tracks i_cpu_pc=0x14 the same cycle.
- With CELDAS=16, send 5 non-halt words → writes at 0, 4, 8, 12, then no 5th write; o_error=1, word_count=4, stall=1; i_start clears o_error and the next word writes at addr 0.
- Byte on i_rx_valid during the WRITE cycle, then 3 more bytes → second word is assembled correctly with no dropped byte.
- Assert reset after 2 bytes of a word, release, pulse i_start, send a full word → write at addr 0 containing only the new bytes.
- In RUN, pulse i_start → stall=1 and load_done=0 next cycle; bytes ignored before i_start are not written.
